// File: rtl/stream_frame_packer_if.sv
// Stream-side and frame-side signals of the frame packer.
// master drives samples and frame_ready; slave is the packer.
interface stream_frame_packer_if #(
    parameter int BITS = 8,
    parameter int N    = 10
);
    logic              in_valid;
    logic [BITS-1:0]   data_in;
    logic              frame_valid;
    logic              frame_ready;
    logic [N*BITS-1:0] frame_data;
    logic              overflow;
    logic [7:0]        drop_count;

    modport master (
        output in_valid, data_in, frame_ready,
        input  frame_valid, frame_data, overflow, drop_count
    );

    modport slave (
        input  in_valid, data_in, frame_ready,
        output frame_valid, frame_data, overflow, drop_count
    );
endinterface

// File: rtl/stream_frame_packer.sv
// Double-buffered packer: serial LLR samples into N-element frames
// handed to the decoder over valid/ready; frames with no free bank drop.
module stream_frame_packer #(
    parameter int BITS = 8,
    parameter int N    = 10
) (
    input logic clk,
    input logic rst_n,
    stream_frame_packer_if.slave bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int W  = N * BITS;

    typedef logic [CW-1:0] cnt_t;

    logic [W-1:0] bank_q [2];
    logic [W-1:0] bank_n [2];
    logic [1:0]   full_q, full_n;
    logic         wr_sel_q, wr_sel_n;
    logic         rd_sel_q, rd_sel_n;
    cnt_t         in_cnt_q, in_cnt_n;
    logic         discard_q, discard_n;

    logic         fv_q;
    logic [W-1:0] fd_q;
    logic         ov_q;
    logic [7:0]   dc_q;

    logic accept, first, last, drop, keep;

    always_comb begin
        full_n    = full_q;
        wr_sel_n  = wr_sel_q;
        rd_sel_n  = rd_sel_q;
        bank_n    = bank_q;
        in_cnt_n  = in_cnt_q;
        discard_n = discard_q;
        drop      = 1'b0;

        accept = fv_q && bus.frame_ready;
        first  = bus.in_valid && (in_cnt_q == '0);
        last   = bus.in_valid && (in_cnt_q == cnt_t'(N - 1));

        if (accept) begin
            full_n[rd_sel_q] = 1'b0;
            rd_sel_n         = ~rd_sel_q;
        end

        // drop check sees the bank already freed by a same-cycle accept
        if (first) begin
            drop      = full_n[wr_sel_q];
            discard_n = drop;
        end

        keep = bus.in_valid && !(first ? drop : discard_q);

        if (keep) begin
            for (int k = 0; k < N; k++) begin
                if (cnt_t'(k) == in_cnt_q)
                    bank_n[wr_sel_q][k*BITS +: BITS] = bus.data_in;
            end
        end

        if (bus.in_valid)
            in_cnt_n = last ? '0 : in_cnt_q + 1'b1;

        if (last) begin
            discard_n = 1'b0;
            if (keep) begin
                full_n[wr_sel_q] = 1'b1;
                wr_sel_n         = ~wr_sel_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q[0] <= '0;
            bank_q[1] <= '0;
            full_q    <= '0;
            wr_sel_q  <= 1'b0;
            rd_sel_q  <= 1'b0;
            in_cnt_q  <= '0;
            discard_q <= 1'b0;
            fv_q      <= 1'b0;
            fd_q      <= '0;
            ov_q      <= 1'b0;
            dc_q      <= '0;
        end else begin
            bank_q[0] <= bank_n[0];
            bank_q[1] <= bank_n[1];
            full_q    <= full_n;
            wr_sel_q  <= wr_sel_n;
            rd_sel_q  <= rd_sel_n;
            in_cnt_q  <= in_cnt_n;
            discard_q <= discard_n;
            fv_q      <= full_n[rd_sel_n];
            fd_q      <= bank_n[rd_sel_n];
            ov_q      <= drop;
            if (drop && dc_q != 8'hFF)
                dc_q <= dc_q + 8'd1;
        end
    end

    assign bus.frame_valid = fv_q;
    assign bus.frame_data  = fd_q;
    assign bus.overflow    = ov_q;
    assign bus.drop_count  = dc_q;
endmodule

// File: tb/tb_stream_frame_packer.sv
// Directed bench for stream_frame_packer: vector table plus
// hand-written sequences for drop, gap, reset and same-cycle cases.
module tb_stream_frame_packer;
    localparam int BITS = 8;
    localparam int N    = 10;
    localparam int W    = N * BITS;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    stream_frame_packer_if #(.BITS(BITS), .N(N)) sif ();

    stream_frame_packer #(.BITS(BITS), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif.slave)
    );

    typedef struct {
        logic         v;
        logic [7:0]   d;
        logic         rdy;
        logic         fv;
        logic         ov;
        logic [7:0]   dc;
        logic         cd;
        logic [W-1:0] fd;
    } vec_t;

    vec_t         tbl [11];
    logic [W-1:0] got [$];
    int           ov_seen;
    int           passed = 0;
    int           total  = 0;
    logic [W-1:0] held;
    logic         stable;

    always @(negedge clk) begin
        if (rst_n && sif.frame_valid && sif.frame_ready)
            got.push_back(sif.frame_data);
        if (rst_n && sif.overflow)
            ov_seen++;
    end

    function automatic logic [W-1:0] fr(input int base);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++)
            r[k*BITS +: BITS] = 8'(base + k);
        return r;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h want %h", name, act, exp);
        else
            passed++;
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        sif.in_valid = v;
        sif.data_in  = d;
        @(posedge clk);
        #1;
        sif.in_valid = 1'b0;
    endtask

    task automatic send(input int base);
        for (int i = 0; i < N; i++)
            step(1'b1, 8'(base + i));
    endtask

    task automatic wait_frames(input int n);
        for (int i = 0; i < 200 && got.size() < n; i++)
            step(1'b0, 8'd0);
    endtask

    initial begin
        rst_n           = 1'b0;
        sif.in_valid    = 1'b0;
        sif.data_in     = '0;
        sif.frame_ready = 1'b0;
        ov_seen         = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fv", W'(sif.frame_valid), W'(1'b0));
        chk("rst_fd", sif.frame_data, '0);
        chk("rst_ov", W'(sif.overflow), W'(1'b0));
        chk("rst_dc", W'(sif.drop_count), W'(8'd0));
        rst_n = 1'b1;
        step(1'b0, 8'd0);

        // single frame, table driven
        for (int i = 0; i < 10; i++) begin
            tbl[i] = '{v: 1'b1, d: 8'(i + 1), rdy: 1'b1,
                       fv: (i == 9), ov: 1'b0, dc: 8'd0,
                       cd: (i == 9), fd: fr(1)};
        end
        tbl[10] = '{v: 1'b0, d: 8'd0, rdy: 1'b1, fv: 1'b0,
                    ov: 1'b0, dc: 8'd0, cd: 1'b0, fd: '0};
        got.delete();
        for (int i = 0; i < 11; i++) begin
            sif.frame_ready = tbl[i].rdy;
            step(tbl[i].v, tbl[i].d);
            chk($sformatf("t1_fv[%0d]", i),
                W'(sif.frame_valid), W'(tbl[i].fv));
            chk($sformatf("t1_ov[%0d]", i),
                W'(sif.overflow), W'(tbl[i].ov));
            chk($sformatf("t1_dc[%0d]", i),
                W'(sif.drop_count), W'(tbl[i].dc));
            if (tbl[i].cd)
                chk($sformatf("t1_fd[%0d]", i), sif.frame_data, tbl[i].fd);
        end
        chk("t1_count", W'(got.size()), W'(1));

        // three back-to-back frames, ready held high
        got.delete();
        ov_seen = 0;
        sif.frame_ready = 1'b1;
        send(1);
        send(11);
        send(21);
        wait_frames(3);
        chk("t2_count", W'(got.size()), W'(3));
        for (int i = 0; i < 3 && i < got.size(); i++)
            chk($sformatf("t2_frame[%0d]", i), got[i], fr(1 + 10 * i));
        chk("t2_dc", W'(sif.drop_count), W'(8'd0));
        chk("t2_ov", W'(ov_seen), W'(0));

        // ready low: third frame is dropped
        got.delete();
        ov_seen = 0;
        sif.frame_ready = 1'b0;
        send(1);
        send(11);
        step(1'b1, 8'd21);
        chk("t3_ov_pulse", W'(sif.overflow), W'(1'b1));
        chk("t3_dc", W'(sif.drop_count), W'(8'd1));
        chk("t3_fv", W'(sif.frame_valid), W'(1'b1));
        step(1'b1, 8'd22);
        chk("t3_ov_fall", W'(sif.overflow), W'(1'b0));
        for (int i = 23; i <= 30; i++)
            step(1'b1, 8'(i));
        chk("t3_held", sif.frame_data, fr(1));
        sif.frame_ready = 1'b1;
        wait_frames(2);
        send(31);
        wait_frames(3);
        chk("t3_count", W'(got.size()), W'(3));
        if (got.size() >= 3) begin
            chk("t3_f0", got[0], fr(1));
            chk("t3_f1", got[1], fr(11));
            chk("t3_f3", got[2], fr(31));
        end
        chk("t3_dc_end", W'(sif.drop_count), W'(8'd1));
        chk("t3_ov_once", W'(ov_seen), W'(1));

        // gaps in in_valid, ready low while holding
        got.delete();
        sif.frame_ready = 1'b0;
        for (int s = 1; s <= 10; s++) begin
            step(1'b1, 8'(s));
            if (s < 10)
                repeat ($urandom_range(1, 3)) step(1'b0, 8'd0);
        end
        chk("t4_fv", W'(sif.frame_valid), W'(1'b1));
        chk("t4_fd", sif.frame_data, fr(1));
        held   = sif.frame_data;
        stable = 1'b1;
        repeat (3) begin
            step(1'b0, 8'd0);
            if (sif.frame_data !== held || sif.frame_valid !== 1'b1)
                stable = 1'b0;
        end
        chk("t4_stable", W'(stable), W'(1'b1));
        sif.frame_ready = 1'b1;
        step(1'b0, 8'd0);
        chk("t4_fv_fall", W'(sif.frame_valid), W'(1'b0));
        sif.frame_ready = 1'b0;

        // completion of A on the same edge as accept of held B
        got.delete();
        ov_seen = 0;
        send(51);
        for (int i = 61; i <= 69; i++)
            step(1'b1, 8'(i));
        sif.frame_ready = 1'b1;
        step(1'b1, 8'd70);
        chk("t6_fv", W'(sif.frame_valid), W'(1'b1));
        chk("t6_fd", sif.frame_data, fr(61));
        chk("t6_b_taken", W'(got.size()), W'(1));
        if (got.size() >= 1)
            chk("t6_b", got[0], fr(51));
        step(1'b0, 8'd0);
        chk("t6_fv_fall", W'(sif.frame_valid), W'(1'b0));
        chk("t6_a", (got.size() >= 2) ? got[1] : '0, fr(61));

        // frame start on the same edge as accept of the wr_sel bank
        got.delete();
        sif.frame_ready = 1'b0;
        send(71);
        send(81);
        sif.frame_ready = 1'b1;
        step(1'b1, 8'd91);
        chk("t7_no_ov", W'(sif.overflow), W'(1'b0));
        for (int i = 92; i <= 100; i++)
            step(1'b1, 8'(i));
        wait_frames(3);
        chk("t7_count", W'(got.size()), W'(3));
        if (got.size() >= 3) begin
            chk("t7_c", got[0], fr(71));
            chk("t7_d", got[1], fr(81));
            chk("t7_e", got[2], fr(91));
        end
        chk("t7_dc", W'(sif.drop_count), W'(8'd1));
        chk("t7_ov", W'(ov_seen), W'(0));

        // asynchronous reset in the middle of a frame
        sif.frame_ready = 1'b1;
        for (int i = 1; i <= 5; i++)
            step(1'b1, 8'(i));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_fv", W'(sif.frame_valid), W'(1'b0));
        chk("t5_fd", sif.frame_data, '0);
        chk("t5_ov", W'(sif.overflow), W'(1'b0));
        chk("t5_dc", W'(sif.drop_count), W'(8'd0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        got.delete();
        for (int i = 1; i <= 9; i++)
            step(1'b1, 8'(i));
        chk("t5_fv_early", W'(sif.frame_valid), W'(1'b0));
        step(1'b1, 8'd10);
        chk("t5_fv_new", W'(sif.frame_valid), W'(1'b1));
        chk("t5_fd_new", sif.frame_data, fr(1));
        chk("t5_dc_new", W'(sif.drop_count), W'(8'd0));
        step(1'b0, 8'd0);
        chk("t5_fv_end", W'(sif.frame_valid), W'(1'b0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/stream_frame_packer.md
Name: stream_frame_packer

Overview:
- Downstream neighbour of the stream interleaver/deinterleaver. It collects the serial BITS-wide LLR stream (bursts of N valid samples, no backpressure) into complete N-element frames.
- Each frame is presented as one flattened word to the max-product SISO decoder through a valid/ready handshake.
- Double-buffered so one frame can be collected while the previous one waits for the decoder.
- Frames that arrive with no free bank are dropped whole and counted.

Parameters:
BITS, 8, width of one LLR sample
N, 10, samples per frame (N >= 2)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  data_in valid this cycle
data_in  input  BITS  LLR sample
frame_valid  output  1  frame_data holds a complete frame
frame_ready  input  1  decoder accepts frame
frame_data  output  N*BITS  element k (arrival order, k=0 first) at [k*BITS +: BITS]
overflow  output  1  one-cycle pulse when a frame drop is decided
drop_count  output  8  frames dropped since reset, saturates at 255

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: frame_valid=0, frame_data=0, overflow=0, drop_count=0.
- Reset internal state: both banks empty, wr_sel=0, rd_sel=0, in_cnt=0, discard=0.
- Reset mid-frame discards the partial frame; nothing is flagged as dropped.
- Storage: two banks of N x BITS, each with a full flag.
- Write side:
  - in_cnt counts 0..N-1 on in_valid, wraps to 0 after N-1.
  - in_cnt advances on every in_valid, including while discarding, so frame alignment is kept.
  - Gaps in in_valid hold in_cnt and all state.
- Drop decision:
  - Made at the frame's first sample (in_valid && in_cnt==0).
  - If full[wr_sel]=1 at that moment: discard=1 for the whole frame, overflow=1 the next cycle, drop_count increments (saturating at 255).
  - The decision is not revisited even if the bank frees mid-frame.
- Normal write (discard=0): sample in_cnt is written to bank[wr_sel][in_cnt].
- Frame completion:
  - On the sample with in_cnt==N-1 and discard=0: full[wr_sel] is set and wr_sel toggles (same edge).
  - If discard=1: discard clears and wr_sel is unchanged.
- Read side:
  - frame_valid = full[rd_sel], registered.
  - Rises the cycle after the edge that writes sample N-1, i.e. one cycle after the last in_valid.
  - frame_data is registered from bank[rd_sel]. It is valid whenever frame_valid=1 and stable while frame_valid && !frame_ready.
  - Accept is frame_valid && frame_ready: full[rd_sel] clears, rd_sel toggles.
  - After accept, if the other bank is full, frame_valid stays 1 with the new frame_data on the next cycle; otherwise frame_valid falls.
  - frame_ready while frame_valid=0 is ignored.
- Simultaneous events:
  - Completion into one bank and accept of the other in the same cycle: both take effect.
  - A frame start coincident with an accept of the bank at wr_sel: the bank is freed, so it is treated as free and the frame is not dropped (accept has priority over the drop check).
- Throughput: with frame_ready held at 1, back-to-back frames (N consecutive in_valid per frame) never drop.
- Invariant: full[] can never be set for a bank already full.

Test Plan:
- N=10, BITS=8; data_in=1..10 on consecutive cycles, frame_ready=1 → frame_valid=1 exactly one cycle after the 10th sample, element k = k+1, accept, frame_valid=0 next cycle, overflow never set.
- Three back-to-back frames (1..10, 11..20, 21..30), frame_ready=1 → three frames in order, one per accept, drop_count=0.
- frame_ready=0, three frames sent → frames 1 and 2 held; at the start of frame 3, overflow pulses for one cycle and drop_count=1. Raise ready → frames 1 and 2 delivered; frame 4 (31..40) delivered correctly.
- Frame with random in_valid gaps (1-3 idle cycles) → contents identical to the gapless case; frame_data stable while ready=0.
- rst_n asserted after 5 of 10 samples → all outputs 0 immediately. Then a fresh frame 1..10 is delivered correctly with drop_count=0.
- Frame-A completion edge coincides with accept of the held frame B → B is consumed, A is presented next cycle, no drop.
